// File: rtl/dram_multiport_arbiter.sv
// rtl/dram_multiport_arbiter.sv - round-robin arbiter serialising NUM_PORTS block requests onto one DRAM backend; optional watchdog under DRAM_ARB_TIMEOUT_EN
module dram_multiport_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int BLOCK_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_PORTS-1:0]                     port_request,
    input  logic [NUM_PORTS-1:0]                     port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]              port_address,
    input  logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0]  port_write_data,
    output logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0]  port_read_data,
    output logic [NUM_PORTS-1:0]                     port_acknowledge,
    output logic [NUM_PORTS-1:0]                     port_busy,
`ifdef DRAM_ARB_TIMEOUT_EN
    output logic [NUM_PORTS-1:0]                     port_error,
`endif
    output logic                                     dram_busy,
    output logic                                     mem_read_enable,
    output logic                                     mem_write_enable,
    output logic [ADDR_W-1:0]                        mem_address,
    output logic [BLOCK_WORDS*WORD_W-1:0]            mem_write_data,
    input  logic [BLOCK_WORDS*WORD_W-1:0]            mem_read_data,
    input  logic                                     mem_acknowledge
);
    localparam int BLK_W = BLOCK_WORDS * WORD_W;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     next_grant;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic [NUM_PORTS-1:0] lat_we;
    logic [ADDR_W-1:0]    lat_addr [NUM_PORTS];
    logic [BLK_W-1:0]     lat_data [NUM_PORTS];

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wd_cnt;
`endif

    assign dram_busy = |port_busy;

    // Per-port request latch; busy clears only at the edge that ends that port's DONE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_busy <= '0;
            lat_we    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                lat_addr[i] <= '0;
                lat_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (port_request[i] && !port_busy[i]) begin
                    port_busy[i] <= 1'b1;
                    lat_we[i]    <= port_we[i];
                    lat_addr[i]  <= port_address[i*ADDR_W +: ADDR_W];
                    lat_data[i]  <= port_write_data[i*BLK_W +: BLK_W];
                end else if (state == DONE && int'(grant) == i) begin
                    port_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search: first busy port after the last granted one, wrapping
    always_comb begin
        found      = 1'b0;
        next_grant = ptr;
        cand       = ptr;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_PORTS);
            if (!found && port_busy[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Transfer FSM with registered backend controls, read-data capture and acknowledge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            ptr              <= IDX_W'(NUM_PORTS - 1);
            grant            <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            port_read_data   <= '0;
            port_acknowledge <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            port_error       <= '0;
            wd_cnt           <= '0;
`endif
        end else begin
            port_acknowledge <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            port_error       <= '0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        grant            <= next_grant;
                        ptr              <= next_grant;
                        mem_address      <= lat_addr[next_grant];
                        mem_write_data   <= lat_data[next_grant];
                        mem_read_enable  <= !lat_we[next_grant];
                        mem_write_enable <= lat_we[next_grant];
`ifdef DRAM_ARB_TIMEOUT_EN
                        wd_cnt           <= '0;
`endif
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_acknowledge) begin
                        mem_read_enable         <= 1'b0;
                        mem_write_enable        <= 1'b0;
                        port_acknowledge[grant] <= 1'b1;
                        if (!lat_we[grant]) begin
                            port_read_data[int'(grant)*BLK_W +: BLK_W] <= mem_read_data;
                        end
                        state <= DONE;
                    end
`ifdef DRAM_ARB_TIMEOUT_EN
                    else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_read_enable         <= 1'b0;
                        mem_write_enable        <= 1'b0;
                        port_acknowledge[grant] <= 1'b1;
                        port_error[grant]       <= 1'b1;
                        state                   <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dram_multiport_arbiter.sv
// tb/tb_dram_multiport_arbiter.sv - directed self-checking bench for dram_multiport_arbiter
module tb_dram_multiport_arbiter;
    localparam int NP  = 3;
    localparam int AW  = 32;
    localparam int WW  = 32;
    localparam int BW  = 4;
    localparam int TO  = 8;
    localparam int BLK = BW * WW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     port_request;
    logic [NP-1:0]     port_we;
    logic [NP*AW-1:0]  port_address;
    logic [NP*BLK-1:0] port_write_data;
    logic [NP*BLK-1:0] port_read_data;
    logic [NP-1:0]     port_acknowledge;
    logic [NP-1:0]     port_busy;
`ifdef DRAM_ARB_TIMEOUT_EN
    logic [NP-1:0]     port_error;
`endif
    logic              dram_busy;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [AW-1:0]     mem_address;
    logic [BLK-1:0]    mem_write_data;
    logic [BLK-1:0]    mem_read_data;
    logic              mem_acknowledge;

    logic [BLK-1:0] be_data;
    logic [BLK-1:0] blk_rr;
    int             ack_delay = 0;
    logic           stray_ack = 1'b0;
    int             wait_cnt  = 0;
    int             cyc       = 0;
    logic           prev_en   = 1'b0;
    int             ack_port [$];
    int             ack_cyc [$];
    logic [AW-1:0]  grant_addr [$];
    int             checks = 0;
    int             passes = 0;

    dram_multiport_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .port_request(port_request), .port_we(port_we),
        .port_address(port_address), .port_write_data(port_write_data),
        .port_read_data(port_read_data), .port_acknowledge(port_acknowledge),
        .port_busy(port_busy),
`ifdef DRAM_ARB_TIMEOUT_EN
        .port_error(port_error),
`endif
        .dram_busy(dram_busy),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_acknowledge(mem_acknowledge)
    );

    always #5 clk = ~clk;

    // Backend model: acknowledges after ack_delay wait cycles of an asserted enable
    assign mem_acknowledge = stray_ack |
        ((mem_read_enable | mem_write_enable) && (wait_cnt >= ack_delay));
    assign mem_read_data = be_data;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        wait_cnt <= (mem_read_enable | mem_write_enable) ? wait_cnt + 1 : 0;
    end

    // Monitor: logs acknowledge pulses and the address of each new grant
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NP; i++)
            if (port_acknowledge[i]) begin
                ack_port.push_back(i);
                ack_cyc.push_back(cyc);
            end
        if ((mem_read_enable | mem_write_enable) && !prev_en)
            grant_addr.push_back(mem_address);
        prev_en = mem_read_enable | mem_write_enable;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_logs();
        ack_port.delete();
        ack_cyc.delete();
        grant_addr.delete();
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        port_address[p*AW +: AW] = a;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        port_request = '0;
        port_we = '0;
        port_address = '0;
        port_write_data = '0;
        be_data = '0;
        step(2);
        checks++;
        if ({port_acknowledge, port_busy, dram_busy, mem_read_enable, mem_write_enable} !== '0)
            $display("FAIL reset_ctrl got ack=%b busy=%b dram_busy=%b re=%b we=%b want all 0",
                     port_acknowledge, port_busy, dram_busy, mem_read_enable, mem_write_enable);
        else passes++;
        checks++;
        if (mem_address !== '0 || mem_write_data !== '0 || port_read_data !== '0)
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0",
                     mem_address, mem_write_data, port_read_data);
        else passes++;
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_round_robin();
        int e;
        clear_logs();
        for (int j = 0; j < BW; j++) blk_rr[j*WW +: WW] = 32'hD0D0_0000 + 32'(j);
        be_data = blk_rr;
        ack_delay = 0;
        @(negedge clk);
        e = cyc + 1;
        port_request = 3'b111;
        port_we = '0;
        for (int i = 0; i < NP; i++) set_addr(i, 32'h1000 + 32'(i) * 32'h100);
        @(negedge clk);
        port_request = '0;
        step(12);
        checks++;
        if (ack_port.size() != 3)
            $display("FAIL rr_ack_count got %0d want 3", ack_port.size());
        else begin
            passes++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ack_port[i] != i || ack_cyc[i] != e + 2 + 3 * i || grant_addr[i] !== 32'h1000 + 32'(i) * 32'h100)
                    $display("FAIL rr_order[%0d] got port=%0d cyc=%0d addr=%h want port=%0d cyc=%0d addr=%h",
                             i, ack_port[i], ack_cyc[i], grant_addr[i], i, e + 2 + 3 * i,
                             32'h1000 + 32'(i) * 32'h100);
                else passes++;
            end
        end
        checks++;
        if (port_read_data[1*BLK +: BLK] !== blk_rr)
            $display("FAIL rr_rdata1 got %h want %h", port_read_data[1*BLK +: BLK], blk_rr);
        else passes++;
        clear_logs();
        @(negedge clk);
        port_request = 3'b101;
        set_addr(0, 32'h1300);
        set_addr(2, 32'h1500);
        @(negedge clk);
        port_request = '0;
        step(9);
        checks++;
        if (ack_port.size() != 2 || grant_addr.size() != 2)
            $display("FAIL rr2_count got acks=%0d grants=%0d want 2 2", ack_port.size(), grant_addr.size());
        else if (ack_port[0] != 0 || ack_port[1] != 2 || grant_addr[0] !== 32'h1300)
            $display("FAIL rr2_order got %0d,%0d first_addr=%h want 0,2 first_addr=00001300",
                     ack_port[0], ack_port[1], grant_addr[0]);
        else passes++;
    endtask

    task automatic test_single_read();
        int e;
        logic [BLK-1:0] exp;
        exp = {32'h44, 32'h33, 32'h22, 32'h11};
        be_data = exp;
        ack_delay = 0;
        clear_logs();
        @(negedge clk);
        e = cyc + 1;
        port_request = 3'b001;
        port_we = '0;
        set_addr(0, 32'h100);
        @(negedge clk);
        port_request = '0;
        checks++;
        if (port_busy !== 3'b001 || dram_busy !== 1'b1)
            $display("FAIL rd_busy got busy=%b dram_busy=%b want 001 1", port_busy, dram_busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_address !== 32'h100)
            $display("FAIL rd_enable got re=%b we=%b addr=%h want 1 0 00000100",
                     mem_read_enable, mem_write_enable, mem_address);
        else passes++;
        @(negedge clk);
        checks++;
        if (port_acknowledge !== 3'b001 || cyc != e + 2 || mem_read_enable !== 1'b0)
            $display("FAIL rd_ack got ack=%b at %0d re=%b want 001 at %0d re=0",
                     port_acknowledge, cyc - e, mem_read_enable, 2);
        else passes++;
        checks++;
        if (port_read_data[0 +: BLK] !== exp)
            $display("FAIL rd_data got %h want %h", port_read_data[0 +: BLK], exp);
        else passes++;
        @(negedge clk);
        checks++;
        if (port_acknowledge !== '0 || port_busy !== '0 || dram_busy !== 1'b0)
            $display("FAIL rd_after got ack=%b busy=%b dram_busy=%b want 000 000 0",
                     port_acknowledge, port_busy, dram_busy);
        else passes++;
    endtask

    task automatic test_write_wait();
        int e;
        int wr_cnt = 0;
        int rd_cnt = 0;
        int bad = 0;
        logic [BLK-1:0] wd;
        for (int j = 0; j < BW; j++) wd[j*WW +: WW] = 32'hA5A5_0000 + 32'(j);
        ack_delay = 5;
        clear_logs();
        @(negedge clk);
        e = cyc + 1;
        port_request = 3'b010;
        port_we = 3'b010;
        set_addr(1, 32'h2000);
        port_write_data[1*BLK +: BLK] = wd;
        @(negedge clk);
        port_request = '0;
        port_we = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                wr_cnt++;
                if (mem_address !== 32'h2000 || mem_write_data !== wd) bad++;
            end
            if (mem_read_enable) rd_cnt++;
        end
        checks++;
        if (wr_cnt != 6 || rd_cnt != 0 || bad != 0)
            $display("FAIL wr_enable got we_cycles=%0d re_cycles=%0d unstable=%0d want 6 0 0",
                     wr_cnt, rd_cnt, bad);
        else passes++;
        checks++;
        if (ack_port.size() != 1)
            $display("FAIL wr_ack_count got %0d want 1", ack_port.size());
        else if (ack_port[0] != 1 || ack_cyc[0] != e + 7)
            $display("FAIL wr_ack got port=%0d at %0d want port=1 at %0d", ack_port[0], ack_cyc[0] - e, 7);
        else passes++;
        checks++;
        if (port_read_data[1*BLK +: BLK] !== blk_rr)
            $display("FAIL wr_rdata1 got %h want %h", port_read_data[1*BLK +: BLK], blk_rr);
        else passes++;
        ack_delay = 0;
    endtask

    task automatic test_rerequest();
        int n = 0;
        ack_delay = 2;
        clear_logs();
        @(negedge clk);
        port_request = 3'b001;
        port_we = '0;
        set_addr(0, 32'h400);
        @(negedge clk);
        set_addr(0, 32'h300);
        while (!port_acknowledge[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        port_request = '0;
        step(6);
        checks++;
        if (ack_port.size() != 1 || grant_addr.size() != 1)
            $display("FAIL rereq_count got acks=%0d grants=%0d want 1 1", ack_port.size(), grant_addr.size());
        else if (grant_addr[0] !== 32'h400)
            $display("FAIL rereq_addr got %h want 00000400", grant_addr[0]);
        else passes++;
        checks++;
        if (dram_busy !== 1'b0)
            $display("FAIL rereq_idle got dram_busy=%b want 0", dram_busy);
        else passes++;
        ack_delay = 0;
    endtask

    task automatic test_stray_ack();
        clear_logs();
        @(negedge clk);
        stray_ack = 1'b1;
        step(3);
        stray_ack = 1'b0;
        step(2);
        checks++;
        if (ack_port.size() != 0 || dram_busy !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0)
            $display("FAIL stray_ack got acks=%0d dram_busy=%b re=%b we=%b want 0 0 0 0",
                     ack_port.size(), dram_busy, mem_read_enable, mem_write_enable);
        else passes++;
    endtask

    task automatic test_reset_mid_busy();
        ack_delay = 1000;
        @(negedge clk);
        port_request = 3'b001;
        set_addr(0, 32'h500);
        @(negedge clk);
        port_request = '0;
        @(negedge clk);
        checks++;
        if (mem_read_enable !== 1'b1)
            $display("FAIL rst_busy_pre got re=%b want 1", mem_read_enable);
        else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || dram_busy !== 1'b0)
            $display("FAIL rst_async got re=%b we=%b dram_busy=%b want 0 0 0",
                     mem_read_enable, mem_write_enable, dram_busy);
        else passes++;
        step(2);
        reset = 1'b1;
        ack_delay = 0;
        clear_logs();
        step(4);
        checks++;
        if (ack_port.size() != 0 || dram_busy !== 1'b0)
            $display("FAIL rst_no_ack got acks=%0d dram_busy=%b want 0 0", ack_port.size(), dram_busy);
        else passes++;
        @(negedge clk);
        port_request = 3'b011;
        set_addr(0, 32'h600);
        set_addr(1, 32'h700);
        @(negedge clk);
        port_request = '0;
        step(8);
        checks++;
        if (grant_addr.size() != 2 || ack_port.size() != 2)
            $display("FAIL rst_grant_count got grants=%0d acks=%0d want 2 2", grant_addr.size(), ack_port.size());
        else if (grant_addr[0] !== 32'h600 || ack_port[0] != 0)
            $display("FAIL rst_first_grant got addr=%h port=%0d want 00000600 0", grant_addr[0], ack_port[0]);
        else passes++;
    endtask

`ifdef DRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int e;
        int n = 0;
        int seen = -1;
        logic [NP-1:0] err = '0;
        logic [NP-1:0] ack = '0;
        ack_delay = 100000;
        @(negedge clk);
        e = cyc + 1;
        port_request = 3'b100;
        port_we = '0;
        set_addr(2, 32'h800);
        @(negedge clk);
        port_request = '0;
        while (seen < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (|port_acknowledge) begin
                seen = cyc;
                err = port_error;
                ack = port_acknowledge;
            end
        end
        checks++;
        if (seen != e + 9 || ack !== 3'b100 || err !== 3'b100)
            $display("FAIL timeout_pulse got at=%0d ack=%b err=%b want at=%0d ack=100 err=100",
                     seen - e, ack, err, 9);
        else passes++;
        @(negedge clk);
        checks++;
        if (port_error !== '0 || port_acknowledge !== '0 || dram_busy !== 1'b0 || mem_read_enable !== 1'b0)
            $display("FAIL timeout_after got err=%b ack=%b dram_busy=%b re=%b want 0",
                     port_error, port_acknowledge, dram_busy, mem_read_enable);
        else passes++;
        checks++;
        if (port_read_data[2*BLK +: BLK] !== '0)
            $display("FAIL timeout_rdata got %h want 0", port_read_data[2*BLK +: BLK]);
        else passes++;
        ack_delay = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_wait();
        test_rerequest();
        test_stray_ack();
        test_reset_mid_busy();
`ifdef DRAM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
